// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake and backpressure.
// Define ADDER_FLAGS_EN to add the registered ovf and zero result flags.
module pipelined_select_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int BPS   = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout
`ifdef ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);
  localparam int NBLK   = WIDTH / BLOCK;
  localparam int STAGES = (NBLK + BPS - 1) / BPS;

  if (BLOCK < 1 || BPS < 1 || WIDTH < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipelined_select_adder: WIDTH must be a positive multiple of BLOCK, BPS >= 1");
  end

  logic adv_s;

  // A held result freezes the whole pipeline, so all stages advance together.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  function automatic logic [BLOCK:0] blk_add(input logic [BLOCK-1:0] x,
                                             input logic [BLOCK-1:0] y,
                                             input logic             ci);
    blk_add = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, ci};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = k * BPS;
    localparam int LAST  = ((k + 1) * BPS < NBLK) ? (k + 1) * BPS : NBLK;

    logic             v_in_s;
    logic             c_in_s;
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;
    logic [WIDTH-1:0] sum_in_s;
    logic [WIDTH-1:0] sum_nxt_s;
    logic             c_nxt_s;
    logic             blk_c_s;
    logic [BLOCK:0]   r0_s;
    logic [BLOCK:0]   r1_s;
    logic             vld_r;
    logic             cy_r;
    logic [WIDTH-1:0] sum_r;

    if (k == 0) begin : g_src
      assign v_in_s   = in_valid;
      assign c_in_s   = sub ? 1'b1 : cin;
      assign a_in_s   = A;
      assign b_in_s   = B ^ {WIDTH{sub}};
      assign sum_in_s = {WIDTH{1'b0}};
    end else begin : g_src
      assign v_in_s   = g_stage[k-1].vld_r;
      assign c_in_s   = g_stage[k-1].cy_r;
      assign a_in_s   = g_stage[k-1].g_hold.a_r;
      assign b_in_s   = g_stage[k-1].g_hold.b_r;
      assign sum_in_s = g_stage[k-1].sum_r;
    end

    // Block arithmetic: the first block ripples (r0 == r1), later blocks select on the running carry.
    always_comb begin
      sum_nxt_s = sum_in_s;
      blk_c_s   = c_in_s;
      r0_s      = {(BLOCK+1){1'b0}};
      r1_s      = {(BLOCK+1){1'b0}};
      for (int j = FIRST; j < LAST; j++) begin
        if (j == FIRST) begin
          r0_s = blk_add(a_in_s[j*BLOCK +: BLOCK], b_in_s[j*BLOCK +: BLOCK], blk_c_s);
          r1_s = r0_s;
        end else begin
          r0_s = blk_add(a_in_s[j*BLOCK +: BLOCK], b_in_s[j*BLOCK +: BLOCK], 1'b0);
          r1_s = blk_add(a_in_s[j*BLOCK +: BLOCK], b_in_s[j*BLOCK +: BLOCK], 1'b1);
        end
        sum_nxt_s[j*BLOCK +: BLOCK] = blk_c_s ? r1_s[BLOCK-1:0] : r0_s[BLOCK-1:0];
        blk_c_s = (r1_s[BLOCK] & blk_c_s) | r0_s[BLOCK];
      end
      c_nxt_s = blk_c_s;
    end

    // Stage register: valid, completed low sum bits and the stage carry.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        vld_r <= 1'b0;
        cy_r  <= 1'b0;
        sum_r <= {WIDTH{1'b0}};
      end else if (adv_s) begin
        vld_r <= v_in_s;
        cy_r  <= c_nxt_s;
        sum_r <= sum_nxt_s;
      end
    end

    if (k < STAGES - 1) begin : g_hold
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      // Operand bits for later stages travel alongside the partial sum.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          a_r <= {WIDTH{1'b0}};
          b_r <= {WIDTH{1'b0}};
        end else if (adv_s) begin
          a_r <= a_in_s;
          b_r <= b_in_s;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_r;
  assign S         = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].cy_r;

`ifdef ADDER_FLAGS_EN
  logic ovf_nxt_s;
  logic zero_nxt_s;

  // Carry into the MSB equals a^b^s at the MSB, so no extra carry needs pipelining.
  assign ovf_nxt_s  = g_stage[STAGES-1].a_in_s[WIDTH-1] ^ g_stage[STAGES-1].b_in_s[WIDTH-1] ^
                      g_stage[STAGES-1].sum_nxt_s[WIDTH-1] ^ g_stage[STAGES-1].c_nxt_s;
  assign zero_nxt_s = (g_stage[STAGES-1].sum_nxt_s == {WIDTH{1'b0}});

  // Flags register beside the final stage and follow its hold rules.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv_s) begin
      ovf  <= ovf_nxt_s;
      zero <= zero_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Scoreboard bench for pipelined_select_adder: default instance plus a 32-bit, 4-stage instance.
`timescale 1ns/1ps
module tb_pipelined_select_adder;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, S;
  logic        cin, sub, cout;
  logic        iv32, ir32, ov32, cin32, sub32, cout32;
  logic [31:0] a32, b32, s32;
`ifdef ADDER_FLAGS_EN
  logic        ovf, zero, ovf32, zero32;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  pipelined_select_adder dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .cout(cout)
`ifdef ADDER_FLAGS_EN
    , .ovf(ovf), .zero(zero)
`endif
  );

  pipelined_select_adder #(.WIDTH(32), .BLOCK(8), .BPS(1)) dut32 (
    .Clk(Clk), .Reset(Reset), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(1'b1), .S(s32), .cout(cout32)
`ifdef ADDER_FLAGS_EN
    , .ovf(ovf32), .zero(zero32)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge Clk) begin
    #2;
    if (!Reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got S=%h cout=%b, required no output", S, cout);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_S", {16'h0000, S}, {16'h0000, mon_e.s});
        check("result_cout", {31'h0, cout}, {31'h0, mon_e.c});
`ifdef ADDER_FLAGS_EN
        check("result_ovf", {31'h0, ovf}, {31'h0, mon_e.ovf});
        check("result_zero", {31'h0, zero}, {31'h0, mon_e.zero});
`endif
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                      input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                      input bit track);
    int n;
    n = 0;
    @(negedge Clk);
    A = a; B = b; cin = c; sub = s; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else if (track) begin
      exp_q.push_back('{s: es, c: ec, ovf: eo, zero: ez});
    end
  endtask

  task automatic idle();
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      #3;
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 60);
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  // Edges counted from the accepting edge (inclusive) until out_valid is seen.
  task automatic lat_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                        input int exp_lat);
    int cnt;
    send(a, b, c, s, es, ec, eo, ez, 1'b1);
    cnt = 0;
    do begin
      @(negedge Clk);
      if (cnt == 0) in_valid = 1'b0;
      cnt++;
      #1;
    end while (!out_valid && cnt < 20);
    check("latency", cnt, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    Reset = 1'b1; in_valid = 1'b0; A = 16'h0; B = 16'h0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    iv32 = 1'b0; a32 = 32'h0; b32 = 32'h0; cin32 = 1'b0; sub32 = 1'b0;

    // 1: reset state, then wrap-around add with 2-cycle latency
    @(negedge Clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_S", {16'h0, S}, 32'd0);
    check("rst_cout", {31'h0, cout}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
    lat_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2);

    // 2, 3: stage-boundary carry, cin, subtract (cin ignored), equal-operand subtract
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    drain();

    // 4: backpressure with four back-to-back ops
    fork
      begin
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
      end
      begin : stall_blk
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge Clk);
          n++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          check("stall_S", {16'h0, S}, 32'h2);
          check("stall_in_ready", {31'h0, in_ready}, 32'd0);
          check("stall_out_valid", {31'h0, out_valid}, 32'd1);
          @(negedge Clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          #1;
          check("no_gap_out_valid", {31'h0, out_valid}, 32'd1);
          @(negedge Clk);
        end
      end
    join
    drain();

    // 5: reset discards an in-flight op; a later op completes normally
    send(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    in_valid = 1'b0;
    Reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("flush_S", {16'h0, S}, 32'd0);
    check("flush_cout", {31'h0, cout}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("flush_out_valid", {31'h0, out_valid}, 32'd0);
      @(negedge Clk);
      #1;
    end
    lat_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2);
    lat_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 2);
    drain();

    // 6: 32-bit, one block per stage -> 4-cycle latency
    @(negedge Clk);
    a32 = 32'hFFFFFFFF; b32 = 32'h00000001; iv32 = 1'b1;
    #1;
    check("w32_in_ready", {31'h0, ir32}, 32'd1);
    cnt = 0;
    do begin
      @(negedge Clk);
      if (cnt == 0) iv32 = 1'b0;
      cnt++;
      #1;
    end while (!ov32 && cnt < 20);
    check("w32_latency", cnt, 32'd4);
    check("w32_S", s32, 32'h0);
    check("w32_cout", {31'h0, cout32}, 32'd1);
`ifdef ADDER_FLAGS_EN
    check("w32_ovf", {31'h0, ovf32}, 32'd0);
    check("w32_zero", {31'h0, zero32}, 32'd1);
`endif
    repeat (3) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_select_adder.md
Name: pipelined_select_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor. It is the next generation of the team's 16-bit carry-select adder, generalised in width, block size and pipeline depth. It adds a subtract mode and a valid/ready handshake with backpressure. It sits between operand registers and the result bus in the datapath and accepts one operation per cycle.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK (elaboration $error otherwise).
BLOCK, 4, bits per carry-select block.
BPS, 2, blocks per pipeline stage; STAGES = ceil((WIDTH/BLOCK)/BPS).

Ports:
Clk  input  1  clock; all state on rising edge.
Reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand valid.
in_ready  output  1  adder can accept operand this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: A+B+cin; 1: A-B (A+~B+1), cin ignored.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
S  output  WIDTH  sum/difference.
cout  output  1  carry-out; in sub mode 1 means no borrow (A>=B unsigned).

Behaviour:
- Reset, checked on the Clk edge while Reset=1: all stage valid bits cleared; S=0; cout=0; out_valid=0. Any in-flight operations are discarded with no output. in_ready=1 during and after reset.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational, with no dependency on in_valid.
- Operand transfer occurs when in_valid & in_ready. Result transfer occurs when out_valid & out_ready.
- When adv=0, every stage register holds. S, cout and out_valid stay stable until the result is accepted.
- Bubbles advance with adv like data: a stage with valid=0 shifts its 0 forward.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1, provided out_ready stays high. Defaults give 2 cycles. Throughput is 1 result/cycle with out_ready held high.
- Stage k (k=0..STAGES-1) operates on blocks k*BPS .. min((k+1)*BPS, NBLK)-1:
  * The first block of the stage ripples with the carry registered from stage k-1. Stage 0 uses the input carry: cin when sub=0, 1 when sub=1.
  * Every other block in the stage computes two sums in parallel, one with carry-in 0 and one with carry-in 1. It then selects by the incoming block carry: c_next = c_blk1 & c_in | c_blk0.
  * Stage register contents: valid bit, the completed low sum bits, the carry out of the stage's last block, and the not-yet-used high A bits and effective-B bits (B^{WIDTH{sub}}).
- The final stage's carry becomes cout. All arithmetic is modulo 2^WIDTH; there is no saturation.
- Order is strictly preserved; there is no reordering or drop under any stall pattern.
- Simultaneous accept and drain in the same cycle is legal and loses no data.
- If the last stage has fewer than BPS blocks, it handles only the remaining blocks.

Optional Feature:
Macro ADDER_FLAGS_EN.
- Defined: adds output ports ovf (1) and zero (1), registered alongside S with the same reset value 0 and the same hold rules.
  * ovf = signed overflow of the effective add: carry into the MSB XOR carry out of the MSB.
  * zero = (S == 0).
- Undefined: neither port exists, and no flag logic is present.

Test Plan:
1. Defaults, Reset for 2 cycles, then A=16'hFFFF, B=16'h0001, cin=0, sub=0 -> out_valid exactly 2 cycles after accept, S=16'h0000, cout=1.
2. A=16'h00FF, B=16'h0001, cin=0 (carry crosses the stage boundary) -> S=16'h0100, cout=0. A=16'h1234, B=16'h4321, cin=1 -> S=16'h5556, cout=0.
3. sub=1: A=16'h0005, B=16'h0007 -> S=16'hFFFE, cout=0. A=16'h0007, B=16'h0005, cin=1 -> S=16'h0002, cout=1 (cin ignored).
4. Backpressure: 4 back-to-back ops (1+1, 2+2, 3+3, 4+4), with out_ready=0 for 3 cycles after the first out_valid:
   - S holds 16'h0002 throughout the stall.
   - in_ready=0 while stalled.
   - Results then emerge in order 2, 4, 6, 8 with no gaps once out_ready=1.
5. Accept A=16'h1111, B=16'h1111; assert Reset on the next cycle for 1 cycle -> out_valid never rises, S=0, cout=0. A new op afterwards completes with normal latency.
6. WIDTH=32, BLOCK=8, BPS=1 -> latency 4 cycles. A=32'hFFFFFFFF, B=32'h1 -> S=0, cout=1.
   - With ADDER_FLAGS_EN defined: zero=1, ovf=0.
   - With ADDER_FLAGS_EN defined, at defaults: A=16'h7FFF, B=16'h0001 -> ovf=1, zero=0.
